temp_threshold_monitor: RTL and testbench
=========================================

Name: temp_threshold_monitor

Overview:
Registered, parametrised successor to the plain magnitude comparator in the temperature-control datapath. It compares each valid temperature sample from the I2C sensor reader against a loadable setpoint. The comparison uses a hysteresis band and a debounce count. It drives a three-state heat/idle/cool controller and registered greater/equal/lower flags that feed the actuator and status logic.

Parameters:
BIT_WIDTH, 8, width of temperature and setpoint words (unsigned).
HYST, 2, hysteresis half-band in LSBs; must be less than 2^BIT_WIDTH.
DEBOUNCE, 3, consecutive qualifying samples required for a state change; must be at least 1.
SETPOINT_RST, 25, setpoint register value after reset.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
sample_valid  in  1  one-cycle strobe: sample_temp is valid this cycle.
sample_temp  in  BIT_WIDTH  temperature sample, unsigned.
setpoint_load  in  1  load setpoint_in into the setpoint register.
setpoint_in  in  BIT_WIDTH  new setpoint value.
output_greater  out  1  last sample > setpoint (registered).
output_equal  out  1  last sample == setpoint (registered).
output_lower  out  1  last sample < setpoint (registered).
state  out  2  00 IDLE, 01 HEAT, 10 COOL; 11 is never driven.
heater_on  out  1  high exactly when state == HEAT.
cooler_on  out  1  high exactly when state == COOL.

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_n. While rst_n is low:
  - setpoint register = SETPOINT_RST;
  - all flags = 0; state = IDLE; heater_on = cooler_on = 0;
  - debounce counter = 0.
- Reset mid-operation takes effect immediately and discards any partial debounce count.
- Thresholds are computed from the current setpoint register in BIT_WIDTH+1 bits:
  - low_thr = max(setpoint - HYST, 0);
  - high_thr = min(setpoint + HYST, 2^BIT_WIDTH - 1).
  - Saturate; never wrap.
- Flags:
  - Updated only on clock edges where sample_valid = 1; otherwise they hold.
  - Latency: 1 cycle from the sample_valid edge.
  - Exactly one flag is high after the first valid sample; all are 0 before it.
- Qualifying condition per state, evaluated on each valid sample:
  - IDLE -> HEAT candidate: sample < low_thr.
  - IDLE -> COOL candidate: sample > high_thr.
  - HEAT -> IDLE candidate: sample >= setpoint.
  - COOL -> IDLE candidate: sample <= setpoint.
- Debounce counter, width clog2(DEBOUNCE+1):
  - Increments on a valid qualifying sample.
  - Clears on a valid non-qualifying sample.
  - Holds on cycles without sample_valid.
- IDLE counting:
  - The counter tracks the candidate direction of the current run.
  - A valid sample qualifying in the opposite direction restarts the count at 1 for that direction.
  - A sample inside [low_thr, high_thr] clears the count.
- Transition timing:
  - When the DEBOUNCE-th consecutive qualifying valid sample arrives, state changes on that same edge; the new state is visible the next cycle.
  - The counter clears on every transition.
  - DEBOUNCE = 1 means immediate transition on the first qualifying sample.
- No direct HEAT<->COOL transition; the path always goes through IDLE.
- heater_on and cooler_on are registered decodes of state; both are never high together.
- Setpoint load:
  - On setpoint_load = 1 the register takes setpoint_in at the edge, and the debounce counter clears.
  - If setpoint_load and sample_valid occur in the same cycle:
    - flags and the qualifying test use the old setpoint;
    - the counter is cleared, i.e. the load wins;
    - no state change occurs that cycle.
  - The state itself is not reset by a load.
- Boundary cases:
  - setpoint = 0 with HYST > 0 gives low_thr = 0, so HEAT is unreachable.
  - setpoint = max gives high_thr = max, so COOL is unreachable.
  - Both cases are legal and required.

Test Plan:
- Reset/idle: BIT_WIDTH=8, HYST=2, DEBOUNCE=3. Release rst_n with no samples -> state=00, all flags 0, heater_on=cooler_on=0, setpoint=25.
- Heat entry: valid samples 22, 22, 22 with idle cycles between -> flags lower=1 after each sample; state=HEAT one cycle after the third edge. Samples 22, 22, 24, 22 -> no transition (24 is inside the band, so the count clears).
- Heat exit/hysteresis: in HEAT, samples 24, 24, 24 -> stays HEAT. Then 25, 26, 25 -> IDLE one cycle after the third. Equal flag=1 after each 25 sample, greater=1 after 26.
- Cool entry and direction change: in IDLE, samples 28, 28, 20, 28, 28, 28 -> the count restarts at the 20 sample; COOL is entered only after the final three 28s; cooler_on=1, heater_on=0.
- Setpoint load collision: in IDLE with two qualifying 28 samples counted, assert setpoint_load=1 (setpoint_in=30) together with sample 28 -> greater=1 (old setpoint 25), counter cleared, state stays IDLE. Samples 33 x3 -> COOL; samples 31 x3 -> no COOL, because with setpoint 30 the band edge is 32.
- Saturation and async reset: setpoint_in=254, HYST=2, samples 255 x5 -> greater=1, state remains IDLE. Pulse rst_n low mid-count (between two edges) -> outputs clear immediately; setpoint returns to 25.

Source files
------------

// File: rtl/temp_threshold_monitor.sv
// temp_threshold_monitor: registered setpoint comparator with hysteresis and debounced heat/idle/cool control
module temp_threshold_monitor #(
  parameter int BIT_WIDTH    = 8,
  parameter int HYST         = 2,
  parameter int DEBOUNCE     = 3,
  parameter int SETPOINT_RST = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic [BIT_WIDTH-1:0] sample_temp,
  input  logic                 setpoint_load,
  input  logic [BIT_WIDTH-1:0] setpoint_in,
  output logic                 output_greater,
  output logic                 output_equal,
  output logic                 output_lower,
  output logic [1:0]           state,
  output logic                 heater_on,
  output logic                 cooler_on
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [1:0] S_IDLE = 2'b00, S_HEAT = 2'b01, S_COOL = 2'b10;
  localparam logic [BIT_WIDTH:0] L_HYST = (BIT_WIDTH+1)'(HYST);
  localparam logic [BIT_WIDTH:0] L_MAX  = {1'b0, {BIT_WIDTH{1'b1}}};
  localparam logic [CW-1:0]      L_DEB  = CW'(DEBOUNCE);
  logic [BIT_WIDTH-1:0] r_sp;
  logic [CW-1:0]        r_cnt, w_cnt_nxt, w_base, w_inc;
  logic                 r_dir, w_dir_nxt;
  logic [1:0]           r_state, w_state_nxt;
  logic                 r_gt, r_eq, r_lt, r_heat, r_cool;
  logic [BIT_WIDTH:0]   w_sp, w_smp, w_sum, w_low, w_high;
  logic                 w_below, w_above, w_qual, w_hit;
  // thresholds are one bit wider so the band saturates instead of wrapping
  always_comb begin
    w_sp    = {1'b0, r_sp};
    w_smp   = {1'b0, sample_temp};
    w_sum   = w_sp + L_HYST;
    w_low   = (w_sp >= L_HYST) ? w_sp - L_HYST : '0;
    w_high  = (w_sum > L_MAX) ? L_MAX : w_sum;
    w_below = w_smp < w_low;
    w_above = w_smp > w_high;
    w_qual  = (r_state == S_IDLE) ? (w_below | w_above) :
              (r_state == S_HEAT) ? (w_smp >= w_sp) : (w_smp <= w_sp);
    // in IDLE a sample pointing the other way restarts the run for that direction
    w_base  = (r_state == S_IDLE && r_cnt != '0 && r_dir != w_above) ? '0 : r_cnt;
    w_inc   = w_base + 1'b1;
    w_hit   = sample_valid && !setpoint_load && w_qual && w_inc == L_DEB;
  end
  always_comb begin
    w_state_nxt = !w_hit ? r_state : (r_state != S_IDLE) ? S_IDLE : (w_above ? S_COOL : S_HEAT);
    w_cnt_nxt   = setpoint_load ? '0 : !sample_valid ? r_cnt : (w_qual && !w_hit) ? w_inc : '0;
    w_dir_nxt   = (sample_valid && r_state == S_IDLE && w_qual) ? w_above : r_dir;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_heat  <= 1'b0;
      r_cool  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_heat  <= w_state_nxt == S_HEAT;
      r_cool  <= w_state_nxt == S_COOL;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= BIT_WIDTH'(SETPOINT_RST);
      r_gt <= 1'b0;
      r_eq <= 1'b0;
      r_lt <= 1'b0;
    end else begin
      if (setpoint_load) r_sp <= setpoint_in;
      if (sample_valid) begin
        r_gt <= w_smp > w_sp;
        r_eq <= w_smp == w_sp;
        r_lt <= w_smp < w_sp;
      end
    end
  end
  always_comb begin
    state          = r_state;
    heater_on      = r_heat;
    cooler_on      = r_cool;
    output_greater = r_gt;
    output_equal   = r_eq;
    output_lower   = r_lt;
  end
endmodule

// File: tb/tb_temp_threshold_monitor.sv
// tb_temp_threshold_monitor: directed stimulus checked every cycle against a behavioural model
module tb_temp_threshold_monitor;
  localparam int HY = 2, DB = 3, MAXV = 255;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sample_valid = 1'b0, setpoint_load = 1'b0;
  logic [7:0] sample_temp = '0, setpoint_in = '0;
  logic       output_greater, output_equal, output_lower, heater_on, cooler_on;
  logic [1:0] state;
  int checks = 0, failures = 0;
  temp_threshold_monitor #(.BIT_WIDTH(8), .HYST(HY), .DEBOUNCE(DB), .SETPOINT_RST(25)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_temp(sample_temp),
    .setpoint_load(setpoint_load), .setpoint_in(setpoint_in), .output_greater(output_greater),
    .output_equal(output_equal), .output_lower(output_lower), .state(state),
    .heater_on(heater_on), .cooler_on(cooler_on));
  always #5 clk = ~clk;
  // model: target state per valid sample (0 none/idle, 1 heat, 2 cool) and length of the current run
  int m_sp = 25, m_state = 0, m_run = 0, m_dir = 0;
  bit m_g = 0, m_e = 0, m_l = 0;
  always @(posedge clk or negedge rst_n) begin
    int s, lo, hi, tgt;
    bit q;
    if (!rst_n) begin
      m_sp = 25; m_state = 0; m_run = 0; m_dir = 0; m_g = 0; m_e = 0; m_l = 0;
    end else begin
      if (sample_valid) begin
        s  = int'(sample_temp);
        lo = (m_sp - HY < 0) ? 0 : m_sp - HY;
        hi = (m_sp + HY > MAXV) ? MAXV : m_sp + HY;
        m_g = s > m_sp; m_e = s == m_sp; m_l = s < m_sp;
        tgt = 0;
        q = 0;
        if (m_state == 0) begin
          if (s < lo) begin q = 1; tgt = 1; end
          else if (s > hi) begin q = 1; tgt = 2; end
        end else if (m_state == 1) q = s >= m_sp;
        else q = s <= m_sp;
        if (setpoint_load || !q) m_run = 0;
        else begin
          if (m_run > 0 && m_dir != tgt) m_run = 0;
          m_dir = tgt;
          m_run++;
          if (m_run == DB) begin m_state = tgt; m_run = 0; end
        end
      end else if (setpoint_load) m_run = 0;
      if (setpoint_load) m_sp = int'(setpoint_in);
    end
  end
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("state", int'(state), m_state);
    chk("heater_on", int'(heater_on), int'(m_state == 1));
    chk("cooler_on", int'(cooler_on), int'(m_state == 2));
    chk("greater", int'(output_greater), int'(m_g));
    chk("equal", int'(output_equal), int'(m_e));
    chk("lower", int'(output_lower), int'(m_l));
  end
  task automatic smp(input int t);
    @(negedge clk); sample_valid = 1'b1; sample_temp = 8'(t);
    @(negedge clk); sample_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic load(input int sp, input bit with_smp, input int t);
    @(negedge clk); setpoint_load = 1'b1; setpoint_in = 8'(sp); sample_valid = with_smp; sample_temp = 8'(t);
    @(negedge clk); setpoint_load = 1'b0; sample_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic lit(input string n, input int st, input int g, input int e, input int l);
    chk({n, " state"}, int'(state), st);
    chk({n, " heat"}, int'(heater_on), int'(st == 1));
    chk({n, " cool"}, int'(cooler_on), int'(st == 2));
    chk({n, " flags"}, int'({output_greater, output_equal, output_lower}), (g << 2) | (e << 1) | l);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lit("reset", 0, 0, 0, 0);
    smp(22); smp(22); smp(24); smp(22);
    lit("band clears", 0, 0, 0, 1);
    smp(22);
    lit("heat count2", 0, 0, 0, 1);
    smp(22);
    lit("heat entry", 1, 0, 0, 1);
    smp(24); smp(24); smp(24);
    lit("heat hyst", 1, 0, 0, 1);
    smp(25);
    lit("heat eq", 1, 0, 1, 0);
    smp(26);
    lit("heat gt", 1, 1, 0, 0);
    smp(25);
    lit("heat exit", 0, 0, 1, 0);
    smp(28); smp(28); smp(20); smp(28); smp(28);
    lit("dir restart", 0, 1, 0, 0);
    smp(28);
    lit("cool entry", 2, 1, 0, 0);
    smp(25); smp(25); smp(25);
    lit("cool exit", 0, 0, 1, 0);
    smp(28); smp(28);
    load(30, 1'b1, 28);
    lit("load collide", 0, 1, 0, 0);
    smp(33); smp(33);
    lit("load cleared", 0, 1, 0, 0);
    smp(33);
    lit("cool sp30", 2, 1, 0, 0);
    smp(30); smp(30); smp(30);
    smp(31); smp(31); smp(31);
    lit("band edge 32", 0, 1, 0, 0);
    load(254, 1'b0, 0);
    repeat (5) smp(255);
    lit("sat high", 0, 1, 0, 0);
    load(0, 1'b0, 0);
    repeat (3) smp(0);
    lit("sat low", 0, 0, 1, 0);
    smp(28); smp(28);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 lit("async reset", 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    smp(28); smp(28);
    lit("count discarded", 0, 1, 0, 0);
    smp(25);
    lit("sp restored", 0, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
